led_matrix_scan_ctrl: RTL
=========================

Name: led_matrix_scan_ctrl

Overview:
Column-scan controller for the 7-row x 10-column LED matrix, organised as two 5-column characters side by side. It sits directly upstream of the row decoders and decoder_mux_2x1_7bits.
- Drives col_index into both decoders and bin_number_sel into the row mux.
- Drives the active-low column lines.
- Inserts a blanking interval at the start of each column slot so rows settle before a column turns on (anti-ghosting).

Parameters:
SLOT_CYCLES, 5000, clk cycles per column slot (>= 2)
BLANK_CYCLES, 50, cycles at the start of each slot with all columns off (1 <= BLANK_CYCLES < SLOT_CYCLES)
NUM_COLS, 5, columns per character; the matrix has 2*NUM_COLS columns

Ports:
clk  input  1  system clock; all state is on its rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  scan enable; low forces scan state to idle
col_index  output  3  column (0..NUM_COLS-1) within the current character, to both row decoders
bin_number_sel  output  1  character select to decoder_mux_2x1_7bits (0 = left decoder, 1 = right decoder)
col_drive_n  output  2*NUM_COLS  one-hot active-low column drive; bit k = physical column k
frame_start  output  1  one-cycle pulse at the start of slot 0

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-high.
- State:
  - Prescaler presc, 0..SLOT_CYCLES-1, width clog2(SLOT_CYCLES).
  - Slot counter slot, 0..2*NUM_COLS-1.
- Reset (asserted at any time, including mid-slot): presc=0, slot=0, col_index=0, bin_number_sel=0, col_drive_n=all ones, frame_start=0.
- enable=0 (synchronous): presc<=0, slot<=0, col_drive_n=all ones, frame_start=0. col_index and bin_number_sel follow slot=0.
- enable=1: presc increments each cycle. At presc==SLOT_CYCLES-1:
  - presc<=0.
  - slot<=slot+1, wrapping from 2*NUM_COLS-1 to 0.
- Derived outputs, all registered, so they change in the same cycle presc changes:
  - col_index = slot mod NUM_COLS.
  - bin_number_sel = (slot >= NUM_COLS).
- Column drive:
  - col_drive_n[slot]=0 only while presc >= BLANK_CYCLES and enable=1; all other bits stay 1.
  - All columns are 1 for presc < BLANK_CYCLES.
  - Active-low is registered, with no combinational path from presc to pins.
  - At most one bit of col_drive_n is ever 0. There is never an overlap between columns at a slot change.
- frame_start = 1 for exactly one cycle: the cycle in which slot==0 and presc==0 while enable=1. This includes the first cycle after enable rises.
- Row path: decoders and the mux are combinational. Rows are valid within BLANK_CYCLES of a col_index/bin_number_sel change; no further latency compensation.
- Slot sequence per frame: 0..4 (sel=0, idx 0..4), then 5..9 (sel=1, idx 0..4).
- Frame length: 2*NUM_COLS*SLOT_CYCLES cycles.
- enable dropped mid-slot: columns blank on the next clock. Re-enable restarts at slot 0 with frame_start.
- Simultaneous reset and enable: reset dominates.

Test Plan:
(All with SLOT_CYCLES=8, BLANK_CYCLES=2, NUM_COLS=5.)
1. Reset then enable=1 held:
   - frame_start=1 on the first enabled cycle.
   - col_drive_n=10'h3FF for 2 cycles, then 10'h3FE for 6 cycles.
   - col_index=0, bin_number_sel=0.
2. Run 80 cycles:
   - Slots 0..9 observed in order.
   - bin_number_sel=0 for slots 0-4 and 1 for slots 5-9.
   - col_index=0,1,2,3,4,0,1,2,3,4.
   - frame_start again at cycle 80.
3. Check every cycle of 3 frames:
   - At most one zero in col_drive_n.
   - All ones on the first 2 cycles after each col_index change.
4. Drop enable in slot 3 at presc=5:
   - Next cycle col_drive_n=10'h3FF, slot=0.
   - Re-enable: frame_start pulse, sequence restarts at slot 0.
5. Assert reset asynchronously in slot 7 at presc=4, between clock edges:
   - Outputs go immediately to reset values (col_drive_n=10'h3FF, sel=0, idx=0).
   - Release resumes from slot 0.
6. SLOT_CYCLES=3, BLANK_CYCLES=2: each column is low for exactly 1 cycle per slot, and the slot wrap 9 to 0 is correct.

Source files
------------

// File: rtl/led_matrix_scan_ctrl.sv
// ----------------------------------------------------------------------------
// led_matrix_scan_ctrl
//
// Column-scan controller for a 7-row x (2*NUM_COLS)-column LED matrix made of
// two NUM_COLS-wide characters side by side. Each column owns a slot of
// SLOT_CYCLES clocks. The first BLANK_CYCLES clocks of every slot keep all
// columns off so the row decoders settle before the new column lights.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   enable         in   scan enable; low returns the scan to idle
//   col_index      out  column within the current character (0..NUM_COLS-1)
//   bin_number_sel out  character select to the row mux (0 = left, 1 = right)
//   col_drive_n    out  one-hot active-low column drive, bit k = column k
//   frame_start    out  one-cycle pulse in the first cycle of slot 0
//
// All outputs are registered and are computed from the next values of the
// prescaler and slot counter, so they change in the same cycle as the
// counters themselves.
// ----------------------------------------------------------------------------
module led_matrix_scan_ctrl #(
    parameter int SLOT_CYCLES  = 5000,
    parameter int BLANK_CYCLES = 50,
    parameter int NUM_COLS     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [2:0]            col_index,
    output logic                  bin_number_sel,
    output logic [2*NUM_COLS-1:0] col_drive_n,
    output logic                  frame_start
);

    localparam int TOTAL_COLS = 2 * NUM_COLS;
    localparam int PRESC_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int SLOT_W     = (TOTAL_COLS > 1) ? $clog2(TOTAL_COLS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SLOT_CYCLES - 1);
    localparam logic [PRESC_W-1:0] PRESC_BLNK = PRESC_W'(BLANK_CYCLES);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(TOTAL_COLS - 1);
    localparam logic [SLOT_W-1:0]  SLOT_HALF  = SLOT_W'(NUM_COLS);

    // IDLE holds the counters at zero; the first enabled edge enters RUN at
    // presc=0/slot=0 (rather than counting past it) so that frame_start is
    // seen on the very first enabled cycle.
    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PRESC_W-1:0]      r_presc;
    logic [PRESC_W-1:0]      w_presc_nxt;
    logic [SLOT_W-1:0]       r_slot;
    logic [SLOT_W-1:0]       w_slot_nxt;
    logic                    w_frame_start_nxt;
    logic                    w_drive_en;
    logic [2:0]              w_col_index_nxt;
    logic                    w_sel_nxt;
    logic [TOTAL_COLS-1:0]   w_drive_n_nxt;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt       = r_state;
        w_presc_nxt       = '0;
        w_slot_nxt        = '0;
        w_frame_start_nxt = 1'b0;
        w_drive_en        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt       = ST_RUN;
                    w_frame_start_nxt = 1'b1;
                end
            end

            ST_RUN: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (r_presc == PRESC_LAST) begin
                        w_presc_nxt       = '0;
                        w_slot_nxt        = (r_slot == SLOT_LAST) ? '0 : r_slot + SLOT_W'(1);
                        w_frame_start_nxt = (r_slot == SLOT_LAST);
                    end else begin
                        w_presc_nxt = r_presc + PRESC_W'(1);
                        w_slot_nxt  = r_slot;
                    end
                    // Column lights only after the blanking part of the slot.
                    w_drive_en = (w_presc_nxt >= PRESC_BLNK);
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase

        w_sel_nxt       = (w_slot_nxt >= SLOT_HALF);
        w_col_index_nxt = w_sel_nxt ? 3'(w_slot_nxt - SLOT_HALF) : 3'(w_slot_nxt);
        w_drive_n_nxt   = w_drive_en ? ~(TOTAL_COLS'(1) << w_slot_nxt) : '1;
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_presc        <= '0;
            r_slot         <= '0;
            col_index      <= '0;
            bin_number_sel <= 1'b0;
            col_drive_n    <= '1;
            frame_start    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here sample
            // the pre-edge values, independent of statement order.
            r_state        <= w_state_nxt;
            r_presc        <= w_presc_nxt;
            r_slot         <= w_slot_nxt;
            col_index      <= w_col_index_nxt;
            bin_number_sel <= w_sel_nxt;
            col_drive_n    <= w_drive_n_nxt;
            frame_start    <= w_frame_start_nxt;
        end
    end

endmodule
